// File: rtl/sprite_pkg.sv
// sprite_pkg: shared raster defaults and types for the sprite mover
package sprite_pkg;
  localparam int H_RES_DEF = 640;
  localparam int V_RES_DEF = 480;
  typedef logic [11:0] rgb444_t;
  typedef logic [10:0] coord_t;
  typedef enum logic {MODE_MANUAL, MODE_AUTO} mode_e;
endpackage

// File: rtl/sprite_axis_step.sv
// sprite_axis_step: combinational next position for one axis; SPRITE_AUTO_EN adds the bounce path
module sprite_axis_step import sprite_pkg::*; #(
  parameter int STEP = 1,
  parameter bit WRAP = 1'b1
) (
  input  coord_t pos_i,
  input  coord_t limit_i,
  input  logic   inc_i,
  input  logic   dec_i,
`ifdef SPRITE_AUTO_EN
  input  logic   auto_i,
  input  logic   dir_i,
  output logic   dir_o,
  output logic   rev_o,
`endif
  output coord_t pos_o
);
  localparam coord_t ST = coord_t'(STEP);
  coord_t up, dn, man;
  logic can_up, can_dn;
  // candidate moves and the manual edge policy; opposing requests cancel
  always_comb begin
    up = pos_i + ST;
    dn = pos_i - ST;
    can_up = up <= limit_i;
    can_dn = pos_i >= ST;
    man = (inc_i && !dec_i) ? (can_up ? up : (WRAP ? '0 : limit_i)) :
          (dec_i && !inc_i) ? (can_dn ? dn : (WRAP ? limit_i : '0)) : pos_i;
  end
`ifdef SPRITE_AUTO_EN
  // auto motion ignores buttons, clamps at the edge and reverses direction
  always_comb begin
    rev_o = dir_i ? !can_up : !can_dn;
    dir_o = auto_i ? dir_i ^ rev_o : dir_i;
    pos_o = !auto_i ? man : dir_i ? (can_up ? up : limit_i) : (can_dn ? dn : '0);
  end
`else
  assign pos_o = man;
`endif
endmodule

// File: rtl/sprite_mover.sv
// sprite_mover: SIZExSIZE sprite moved per refresh tick; define SPRITE_AUTO_EN for AUTO bounce mode
module sprite_mover import sprite_pkg::*; #(
  parameter int      H_RES = H_RES_DEF,
  parameter int      V_RES = V_RES_DEF,
  parameter int      SIZE  = 25,
  parameter int      STEP  = 1,
  parameter int      X0    = 100,
  parameter int      Y0    = 150,
  parameter rgb444_t COLOR = 12'h5AF,
  parameter bit      WRAP  = 1'b1
) (
  input  logic       clk,
  input  logic       rstn,
  input  logic       refr_tick,
  input  logic       btn_r,
  input  logic       btn_l,
  input  logic       btn_u,
  input  logic       btn_d,
  input  logic       mode_tgl,
  input  logic [9:0] pixel_x,
  input  logic [9:0] pixel_y,
  output logic       sprite_on,
  output rgb444_t    sprite_rgb,
  output logic [9:0] pos_x,
  output logic [9:0] pos_y,
  output logic       auto_mode,
  output logic       bounce
);
  localparam coord_t LIM_X = coord_t'(H_RES - SIZE);
  localparam coord_t LIM_Y = coord_t'(V_RES - SIZE);
  localparam coord_t SZ    = coord_t'(SIZE);
  coord_t x_q, y_q, x_d, y_d, px, py;
  logic hit, on_q, unused_msb;
  rgb444_t rgb_q;
`ifdef SPRITE_AUTO_EN
  mode_e state_q;
  logic tgl_q, is_auto, dir_x_q, dir_y_q, dir_x_d, dir_y_d, rev_x, rev_y, bounce_q;
  assign is_auto = state_q == MODE_AUTO;
  // mode FSM: each rising edge of mode_tgl flips MANUAL/AUTO
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      tgl_q   <= 1'b0;
      state_q <= MODE_MANUAL;
    end else begin
      tgl_q <= mode_tgl;
      if (mode_tgl && !tgl_q) state_q <= is_auto ? MODE_MANUAL : MODE_AUTO;
    end
  // directions follow the axis steppers on ticks; bounce flags any AUTO reversal
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      dir_x_q  <= 1'b1;
      dir_y_q  <= 1'b1;
      bounce_q <= 1'b0;
    end else begin
      bounce_q <= refr_tick && is_auto && (rev_x || rev_y);
      if (refr_tick) begin
        dir_x_q <= dir_x_d;
        dir_y_q <= dir_y_d;
      end
    end
  assign auto_mode = is_auto;
  assign bounce    = bounce_q;
`else
  logic unused_tgl;
  assign unused_tgl = mode_tgl;
  assign auto_mode  = 1'b0;
  assign bounce     = 1'b0;
`endif
  sprite_axis_step #(.STEP(STEP), .WRAP(WRAP)) u_x (
    .pos_i(x_q), .limit_i(LIM_X), .inc_i(btn_r), .dec_i(btn_l),
`ifdef SPRITE_AUTO_EN
    .auto_i(is_auto), .dir_i(dir_x_q), .dir_o(dir_x_d), .rev_o(rev_x),
`endif
    .pos_o(x_d)
  );
  sprite_axis_step #(.STEP(STEP), .WRAP(WRAP)) u_y (
    .pos_i(y_q), .limit_i(LIM_Y), .inc_i(btn_d), .dec_i(btn_u),
`ifdef SPRITE_AUTO_EN
    .auto_i(is_auto), .dir_i(dir_y_q), .dir_o(dir_y_d), .rev_o(rev_y),
`endif
    .pos_o(y_d)
  );
  // position advances only on the frame tick
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      x_q <= coord_t'(X0);
      y_q <= coord_t'(Y0);
    end else if (refr_tick) begin
      x_q <= x_d;
      y_q <= y_d;
    end
  assign px  = {1'b0, pixel_x};
  assign py  = {1'b0, pixel_y};
  assign hit = px >= x_q && px < x_q + SZ && py >= y_q && py < y_q + SZ;
  // registered hit and colour for the pixel mux
  always_ff @(posedge clk or negedge rstn)
    if (!rstn) begin
      on_q  <= 1'b0;
      rgb_q <= '0;
    end else begin
      on_q  <= hit;
      rgb_q <= hit ? COLOR : '0;
    end
  assign sprite_on  = on_q;
  assign sprite_rgb = rgb_q;
  assign pos_x      = x_q[9:0];
  assign pos_y      = y_q[9:0];
  assign unused_msb = x_q[10] ^ y_q[10];
endmodule

// File: tb/tb_sprite_mover.sv
// tb_sprite_mover: scoreboard bench for sprite_mover, wrapping (dut) and clamping (dutc) instances
module tb_sprite_mover;
  import sprite_pkg::*;
  localparam logic [3:0] R = 4'b1000, L = 4'b0100, U = 4'b0010, D = 4'b0001;
  logic clk = 0, rstn = 0, tick = 0, br = 0, bl = 0, bu = 0, bd = 0, tgl = 0;
  logic [9:0] pxx = 0, pxy = 0;
  logic on_w, on_c, am_w, am_c, bn_w, bn_c;
  rgb444_t rgb_w, rgb_c;
  logic [9:0] x_w, y_w, x_c, y_c;
  int cyc = 0, checks = 0, errors = 0;
  typedef enum int {SX, SY, SCX, SCY, SON, SRGB, SAM, SBN} sig_e;
  typedef struct {string name; sig_e sig; int val; int due;} exp_t;
  exp_t q[$];

  sprite_mover dut (
    .clk(clk), .rstn(rstn), .refr_tick(tick), .btn_r(br), .btn_l(bl), .btn_u(bu), .btn_d(bd),
    .mode_tgl(tgl), .pixel_x(pxx), .pixel_y(pxy), .sprite_on(on_w), .sprite_rgb(rgb_w),
    .pos_x(x_w), .pos_y(y_w), .auto_mode(am_w), .bounce(bn_w));
  sprite_mover #(.WRAP(1'b0)) dutc (
    .clk(clk), .rstn(rstn), .refr_tick(tick), .btn_r(br), .btn_l(bl), .btn_u(bu), .btn_d(bd),
    .mode_tgl(tgl), .pixel_x(pxx), .pixel_y(pxy), .sprite_on(on_c), .sprite_rgb(rgb_c),
    .pos_x(x_c), .pos_y(y_c), .auto_mode(am_c), .bounce(bn_c));

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic int obs(sig_e s);
    return s == SX ? int'(x_w) : s == SY ? int'(y_w) : s == SCX ? int'(x_c) :
           s == SCY ? int'(y_c) : s == SON ? int'(on_w) : s == SRGB ? int'(rgb_w) :
           s == SAM ? int'(am_w) : int'(bn_w);
  endfunction

  always @(negedge clk) begin : mon
    exp_t e;
    int a;
    while (q.size() > 0 && q[0].due <= cyc) begin
      e = q.pop_front();
      a = obs(e.sig);
      checks++;
      if (a != e.val) begin
        errors++;
        $display("FAIL %s: got %0d expected %0d", e.name, a, e.val);
      end
    end
  end

  task automatic ex(input string n, input sig_e s, input int v, input int lat = 1);
    q.push_back('{name: n, sig: s, val: v, due: cyc + lat});
  endtask
  task automatic set(input logic t, input logic [3:0] b, input logic g);
    tick = t;
    {br, bl, bu, bd} = b;
    tgl = g;
  endtask
  task automatic nxt();
    @(posedge clk);
    #1;
  endtask
  task automatic chk_pos(input string n, input int x, input int y, input int cx, input int cy, input int lat = 1);
    ex({n, ".x"}, SX, x, lat);
    ex({n, ".y"}, SY, y, lat);
    ex({n, ".cx"}, SCX, cx, lat);
    ex({n, ".cy"}, SCY, cy, lat);
  endtask
  task automatic mv(input string n, input logic [3:0] b, input int x, input int y, input int cx, input int cy);
    set(1, b, 0);
    chk_pos(n, x, y, cx, cy);
    nxt();
  endtask
  task automatic go(input int n, input logic [3:0] b);
    set(1, b, 0);
    repeat (n) nxt();
    set(0, 0, 0);
  endtask
  task automatic do_reset();
    nxt();
    #1 rstn = 0;
    chk_pos("rst", 100, 150, 100, 150, 0);
    ex("rst.on", SON, 0, 0);
    ex("rst.am", SAM, 0, 0);
    ex("rst.bn", SBN, 0, 0);
    nxt();
    rstn = 1;
  endtask

  initial begin
    set(0, 0, 0);
    nxt();
    chk_pos("init", 100, 150, 100, 150, 0);
    ex("init.on", SON, 0, 0);
    ex("init.rgb", SRGB, 0, 0);
    ex("init.am", SAM, 0, 0);
    nxt();
    rstn = 1;
    pxx = 100; pxy = 150; ex("hit.on", SON, 1); ex("hit.rgb", SRGB, 12'h5AF); nxt();
    pxx = 125; ex("xend.on", SON, 0); ex("xend.rgb", SRGB, 0); nxt();
    pxx = 124; pxy = 174; ex("corner.on", SON, 1); nxt();
    pxx = 100; pxy = 175; ex("yend.on", SON, 0); nxt();
    pxx = 99;  pxy = 150; ex("xlow.on", SON, 0); nxt();
    pxx = 0; pxy = 0;
    mv("first", R, 101, 150, 101, 150);
    go(304, R | D);
    go(209, R);
    chk_pos("at", 614, 454, 614, 454); nxt();
    mv("w1", R, 615, 454, 615, 454);
    mv("w2", R, 0, 454, 615, 454);
    mv("w3", L, 615, 454, 614, 454);
    mv("rl", R | L, 615, 454, 614, 454);
    mv("c1", R, 0, 454, 615, 454);
    mv("c2", R, 1, 454, 615, 454);
    mv("c3", R, 2, 454, 615, 454);
    mv("dr", D | R, 3, 455, 615, 455);
    mv("d", D, 3, 0, 615, 455);
    mv("u", U, 3, 455, 615, 454);
    mv("ud", U | D, 3, 455, 615, 454);
    set(0, R, 0); chk_pos("hold", 3, 455, 615, 454); nxt();
    set(0, 0, 0); pxx = 3; pxy = 455; ex("pre.on", SON, 1); nxt();
    do_reset();
    pxx = 0; pxy = 0;
    mv("rel", D, 100, 151, 100, 151);
`ifdef SPRITE_AUTO_EN
    go(303, R | D);
    go(211, R);
    set(0, 0, 1); ex("am.on", SAM, 1); nxt();
    set(0, 0, 1); ex("am.hold", SAM, 1); nxt();
    set(1, L, 0); chk_pos("a1", 615, 455, 615, 455); ex("a1.bn", SBN, 0); nxt();
    set(1, L, 0); chk_pos("a2", 615, 455, 615, 455); ex("a2.bn", SBN, 1); nxt();
    set(1, L, 0); chk_pos("a3", 614, 454, 614, 454); ex("a3.bn", SBN, 0); nxt();
    set(0, 0, 1); ex("man.am", SAM, 0); nxt();
    set(0, 0, 0); nxt();
    set(1, R, 1); chk_pos("te", 615, 454, 615, 454); ex("te.am", SAM, 1); nxt();
    set(1, R | D, 1); chk_pos("ign", 614, 453, 614, 453); nxt();
    set(0, 0, 0);
    do_reset();
    set(0, 0, 1); ex("dir.am", SAM, 1); nxt();
    set(1, 0, 0); chk_pos("dir", 101, 151, 101, 151); nxt();
`else
    set(0, 0, 1); ex("na.am1", SAM, 0); nxt();
    set(0, 0, 0); nxt();
    set(1, R, 1); chk_pos("na", 101, 151, 101, 151); ex("na.am2", SAM, 0); ex("na.bn", SBN, 0); nxt();
    set(1, R, 0); chk_pos("na2", 102, 151, 102, 151); ex("na.am3", SAM, 0); nxt();
`endif
    set(0, 0, 0);
    repeat (3) nxt();
    if (q.size() != 0) begin
      errors += q.size();
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
